// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out handshake bundle for conv_window_gen.
// win_idx exists only when CONV_WINDOW_GEN_IDX_EN is defined.
interface conv_window_gen_if #(
  parameter int IntSize = 8,
  parameter int K       = 5
);
  logic [IntSize-1:0]     pix_data;
  logic                   pix_valid;
  logic                   pix_sof;
  logic                   pix_ready;
  logic [K*K*IntSize-1:0] win_data;
  logic                   win_valid;
  logic                   win_ready;
  logic                   frame_done;
`ifdef CONV_WINDOW_GEN_IDX_EN
  logic [9:0]             win_idx;

  modport master (output pix_data, pix_valid, pix_sof, win_ready,
                  input  pix_ready, win_data, win_valid, frame_done, win_idx);
  modport slave  (input  pix_data, pix_valid, pix_sof, win_ready,
                  output pix_ready, win_data, win_valid, frame_done, win_idx);
`else
  modport master (output pix_data, pix_valid, pix_sof, win_ready,
                  input  pix_ready, win_data, win_valid, frame_done);
  modport slave  (input  pix_data, pix_valid, pix_sof, win_ready,
                  output pix_ready, win_data, win_valid, frame_done);
`endif
endinterface

// File: rtl/conv_window_gen.sv
// Raster-order KxK sliding-window generator; window out 1 cycle after its bottom-right pixel,
// single output register so pix_ready drops while a window is stalled. CONV_WINDOW_GEN_IDX_EN adds win_idx.
module conv_window_gen #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int K       = 5,
  parameter int IntSize = 8
) (
  input logic             clk,
  input logic             rst,
  conv_window_gen_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]          col_q, col_d, eff_col;
  logic [RW-1:0]          row_q, row_d, eff_row;
  logic                   pix_ready, pix_acc, emit, last_pix;
  logic [IntSize-1:0]     lb_q  [K-1][IMG_W];
  logic [IntSize-1:0]     col_new [K];
  logic [IntSize-1:0]     win_q [K][K];
  logic [IntSize-1:0]     win_d [K][K];
  logic [K*K*IntSize-1:0] win_pack, win_data_q;
  logic                   win_valid_q, win_valid_d, win_last_q, frame_done_q;

  assign pix_ready = !win_valid_q || bus.win_ready;
  assign pix_acc   = bus.pix_valid && pix_ready;

  // A start-of-frame pixel is (0,0) regardless of where the counters were.
  assign eff_col  = bus.pix_sof ? '0 : col_q;
  assign eff_row  = bus.pix_sof ? '0 : row_q;
  assign emit     = pix_acc && (eff_row >= RW'(K-1)) && (eff_col >= CW'(K-1));
  assign last_pix = (eff_row == RW'(IMG_H-1)) && (eff_col == CW'(IMG_W-1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_acc) begin
      if (eff_col == CW'(IMG_W-1)) begin
        col_d = '0;
        row_d = (eff_row == RW'(IMG_H-1)) ? '0 : eff_row + 1'b1;
      end else begin
        col_d = eff_col + 1'b1;
        row_d = eff_row;
      end
    end
  end

  // Incoming column: the K-1 buffered rows above this pixel (oldest first), then the pixel itself.
  always_comb begin
    for (int r = 0; r < K-1; r++) col_new[r] = lb_q[r][eff_col];
    col_new[K-1] = bus.pix_data;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K-1; c++) win_d[r][c] = win_q[r][c+1];
      win_d[r][K-1] = col_new[r];
    end
  end

  always_comb begin
    win_pack = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win_pack[(r*K+c)*IntSize +: IntSize] = win_d[r][c];
  end

  assign win_valid_d = emit || (win_valid_q && !bus.win_ready);

  always_ff @(posedge clk) begin
    if (pix_acc) begin
      for (int r = 0; r < K-2; r++) lb_q[r][eff_col] <= lb_q[r+1][eff_col];
      lb_q[K-2][eff_col] <= bus.pix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '{default: '0};
      win_data_q   <= '0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= win_valid_q && bus.win_ready && win_last_q;
      if (pix_acc) win_q <= win_d;
      if (emit) begin
        win_data_q <= win_pack;
        win_last_q <= last_pix;
      end
    end
  end

`ifdef CONV_WINDOW_GEN_IDX_EN
  logic [9:0] win_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_idx_q <= '0;
    end else if (emit) begin
      win_idx_q <= 10'((int'(eff_row) - (K-1)) * (IMG_W-K+1) + (int'(eff_col) - (K-1)));
    end
  end

  assign bus.win_idx = win_idx_q;
`endif

  assign bus.pix_ready  = pix_ready;
  assign bus.win_data   = win_data_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: image-array reference model fed from observed pixel handshakes.
`timescale 1ns/1ps
module tb_conv_window_gen;
  localparam int W = 28, H = 28, K = 5, N = K*K*8, FR = W*H;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_gen_if #(.IntSize(8), .K(K)) u_if ();
  conv_window_gen #(.IMG_W(W), .IMG_H(H), .K(K), .IntSize(8)) dut (
    .clk(clk), .rst(rst), .bus(u_if.slave));

  typedef struct { logic [N-1:0] dat; int idx; bit last; } win_t;
  typedef struct { bit had; win_t e; logic [N-1:0] od; int oi; } res_t;

  win_t exp_q[$];
  res_t res_q[$];
  int   errors = 0, checks = 0, fd_cnt = 0;
  int   m_r = 0, m_c = 0;
  logic [7:0] img [H][W];

  // Reference: place each accepted pixel in a 2-D frame image and cut out the KxK block ending at it.
  always @(negedge clk) begin : mon
    res_t p;
    win_t w;
    if (rst) begin
      m_r = 0; m_c = 0; exp_q.delete();
    end else begin
      if (u_if.win_valid && u_if.win_ready) begin
        p.had = (exp_q.size() > 0);
        p.e.dat = '0; p.e.idx = -1; p.e.last = 0;
        if (p.had) p.e = exp_q.pop_front();
        p.od = u_if.win_data;
`ifdef CONV_WINDOW_GEN_IDX_EN
        p.oi = int'(u_if.win_idx);
`else
        p.oi = -1;
`endif
        res_q.push_back(p);
      end
      if (u_if.pix_valid && u_if.pix_ready) begin
        if (u_if.pix_sof) begin m_r = 0; m_c = 0; end
        img[m_r][m_c] = u_if.pix_data;
        if (m_r >= K-1 && m_c >= K-1) begin
          w.dat = '0;
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
              w.dat[8*(i*K+j) +: 8] = img[m_r-K+1+i][m_c-K+1+j];
          w.idx  = (m_r-K+1)*(W-K+1) + (m_c-K+1);
          w.last = (m_r == H-1 && m_c == W-1);
          exp_q.push_back(w);
        end
        m_c++;
        if (m_c == W) begin m_c = 0; m_r++; if (m_r == H) m_r = 0; end
      end
      if (u_if.frame_done) fd_cnt++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_pixels(input int n, input int k0, input int vpct, input int rpct,
                            input bit rnd, input int sof_at, output bit ok);
    int k = 0, t = 0;
    while (k < n && t < 30000) begin
      u_if.pix_valid = ($urandom_range(99) < vpct);
      u_if.pix_data  = rnd ? 8'($urandom) : 8'(((k0 + k) % FR) % 256);
      u_if.pix_sof   = (k == sof_at);
      u_if.win_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (u_if.pix_valid && u_if.pix_ready) k++;
      step(); t++;
    end
    u_if.pix_valid = 1'b0; u_if.pix_sof = 1'b0;
    ok = (k == n);
  endtask

  task automatic drain(output bit ok);
    int t = 0;
    u_if.pix_valid = 1'b0; u_if.pix_sof = 1'b0; u_if.win_ready = 1'b1;
    while (u_if.win_valid && t < 50) begin step(); t++; end
    repeat (3) step();
    ok = (t < 50);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    u_if.pix_valid = 1'b0; u_if.pix_sof = 1'b0; u_if.pix_data = '0; u_if.win_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (u_if.win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid: got %b want 0", u_if.win_valid); end
    if (u_if.win_data !== '0) begin errors++; $display("FAIL reset_win_data: got %h want 0", u_if.win_data); end
    if (u_if.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", u_if.frame_done); end
    if (u_if.pix_ready !== 1'b1) begin errors++; $display("FAIL reset_pix_ready: got %b want 1", u_if.pix_ready); end
`ifdef CONV_WINDOW_GEN_IDX_EN
    checks++;
    if (u_if.win_idx !== 10'd0) begin errors++; $display("FAIL reset_win_idx: got %0d want 0", u_if.win_idx); end
`endif
    step();
  endtask

  task automatic test_ramp();
    res_t got[$];
    bit ok1, ok2;
    int fd0 = fd_cnt;
    res_q.delete();
    run_pixels(FR, 0, 100, 100, 0, -1, ok1);
    drain(ok2);
    got = res_q; res_q.delete();
    checks += 3;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL ramp_timeout: got %b%b want 11", ok1, ok2); end
    if (got.size() != 576) begin errors++; $display("FAIL ramp_count: got %0d want 576", got.size()); end
    if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL ramp_frame_done: got %0d want 1", fd_cnt - fd0); end
    foreach (got[i]) begin
      checks++;
      if (!got[i].had || got[i].od !== got[i].e.dat) begin
        errors++; $display("FAIL ramp_win[%0d]: got %h want %h", i, got[i].od, got[i].e.dat);
      end
    end
    if (got.size() >= 576) begin
      checks += 3;
      if (got[0].od[7:0] !== 8'h00) begin errors++; $display("FAIL ramp_e0: got %h want 00", got[0].od[7:0]); end
      if (got[0].od[39:32] !== 8'h04) begin errors++; $display("FAIL ramp_e4: got %h want 04", got[0].od[39:32]); end
      if (got[0].od[199:192] !== 8'd116) begin errors++; $display("FAIL ramp_e24: got %0d want 116", got[0].od[199:192]); end
`ifdef CONV_WINDOW_GEN_IDX_EN
      for (int i = 0; i < 25; i++) begin
        checks++;
        if (got[i].oi != i) begin errors++; $display("FAIL ramp_idx[%0d]: got %0d want %0d", i, got[i].oi, i); end
      end
      checks++;
      if (got[575].oi != 575) begin errors++; $display("FAIL ramp_idx_last: got %0d want 575", got[575].oi); end
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] first_win;
    bit ok1, ok2, ok3;
    int nw = 0, fd0 = fd_cnt;
    res_t p;
    res_q.delete();
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        first_win[8*(r*K+c) +: 8] = 8'((r*W + c) % 256);
    run_pixels(4*W + 5, 0, 100, 100, 0, -1, ok1);
    u_if.win_ready = 1'b0; u_if.pix_valid = 1'b1; u_if.pix_data = 8'(4*W + 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks += 3;
      if (u_if.pix_ready !== 1'b0) begin errors++; $display("FAIL bp_pix_ready[%0d]: got %b want 0", i, u_if.pix_ready); end
      if (u_if.win_valid !== 1'b1) begin errors++; $display("FAIL bp_win_valid[%0d]: got %b want 1", i, u_if.win_valid); end
      if (u_if.win_data !== first_win) begin errors++; $display("FAIL bp_hold[%0d]: got %h want %h", i, u_if.win_data, first_win); end
      step();
    end
    run_pixels(FR - (4*W + 5), 4*W + 5, 100, 100, 0, -1, ok2);
    drain(ok3);
    while (res_q.size() > 0) begin
      p = res_q.pop_front();
      checks++;
      if (!p.had || p.od !== p.e.dat) begin errors++; $display("FAIL bp_win[%0d]: got %h want %h", nw, p.od, p.e.dat); end
      nw++;
    end
    checks += 3;
    if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL bp_timeout: got %b%b%b want 111", ok1, ok2, ok3); end
    if (nw != 576) begin errors++; $display("FAIL bp_count: got %0d want 576", nw); end
    if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL bp_frame_done: got %0d want 1", fd_cnt - fd0); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int nw = 0, fd0 = fd_cnt;
    res_t p;
    res_q.delete();
    run_pixels(3*FR, 0, 50, 50, 1, -1, ok1);
    drain(ok2);
    while (res_q.size() > 0) begin
      p = res_q.pop_front();
      checks++;
      if (!p.had || p.od !== p.e.dat) begin errors++; $display("FAIL b2b_win[%0d]: got %h want %h", nw, p.od, p.e.dat); end
`ifdef CONV_WINDOW_GEN_IDX_EN
      checks++;
      if (p.oi != nw % 576) begin errors++; $display("FAIL b2b_idx[%0d]: got %0d want %0d", nw, p.oi, nw % 576); end
`endif
      nw++;
    end
    checks += 3;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL b2b_timeout: got %b%b want 11", ok1, ok2); end
    if (nw != 1728) begin errors++; $display("FAIL b2b_count: got %0d want 1728", nw); end
    if (fd_cnt - fd0 != 3) begin errors++; $display("FAIL b2b_frame_done: got %0d want 3", fd_cnt - fd0); end
  endtask

  task automatic test_sof_resync();
    bit ok1, ok2, ok3, ok4, ok5, ok6, ok7, ok8, ok9, ok10;
    int nw = 0, fd0 = fd_cnt, n_pre, n_wait, n_first, n_last;
    res_t p;
    res_q.delete();
    run_pixels(300, 0, 100, 100, 1, -1, ok1); drain(ok2);
    n_pre = res_q.size();
    run_pixels(4*W + 4, 0, 100, 100, 1, 0, ok3); drain(ok4);
    n_wait = res_q.size() - n_pre;
    run_pixels(1, 0, 100, 100, 1, -1, ok5); drain(ok6);
    n_first = res_q.size() - n_pre - n_wait;
    run_pixels(FR - (4*W + 5) - 1, 0, 50, 50, 1, -1, ok7); drain(ok8);
    checks += 5;
    if (fd_cnt - fd0 != 0) begin errors++; $display("FAIL sof_early_done: got %0d want 0", fd_cnt - fd0); end
    run_pixels(1, 0, 100, 100, 1, -1, ok9); drain(ok10);
    n_last = res_q.size() - n_pre;
    if (n_pre != 160) begin errors++; $display("FAIL sof_pre_count: got %0d want 160", n_pre); end
    if (n_wait != 0 || n_first != 1) begin errors++; $display("FAIL sof_first_win: got %0d/%0d want 0/1", n_wait, n_first); end
    if (n_last != 576) begin errors++; $display("FAIL sof_count: got %0d want 576", n_last); end
    if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL sof_frame_done: got %0d want 1", fd_cnt - fd0); end
    while (res_q.size() > 0) begin
      p = res_q.pop_front();
      checks++;
      if (!p.had || p.od !== p.e.dat) begin errors++; $display("FAIL sof_win[%0d]: got %h want %h", nw, p.od, p.e.dat); end
      nw++;
    end
    checks++;
    if (!(ok1 && ok2 && ok3 && ok4 && ok5 && ok6 && ok7 && ok8 && ok9 && ok10)) begin
      errors++; $display("FAIL sof_timeout: got 0 want 1");
    end
  endtask

  task automatic test_reset_midframe();
    bit ok1, ok2, ok3;
    int nw = 0, fd0;
    res_t p;
    res_q.delete();
    run_pixels(400, 0, 100, 100, 1, -1, ok1);
    u_if.win_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (u_if.win_valid !== 1'b0) begin errors++; $display("FAIL rstmid_win_valid: got %b want 0", u_if.win_valid); end
    if (res_q.size() != 243) begin errors++; $display("FAIL rstmid_pre_count: got %0d want 243", res_q.size()); end
    res_q.delete();
    step();
    fd0 = fd_cnt;
    run_pixels(FR, 0, 50, 50, 1, -1, ok2);
    drain(ok3);
    while (res_q.size() > 0) begin
      p = res_q.pop_front();
      checks++;
      if (!p.had || p.od !== p.e.dat) begin errors++; $display("FAIL rstmid_win[%0d]: got %h want %h", nw, p.od, p.e.dat); end
      nw++;
    end
    checks += 3;
    if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL rstmid_timeout: got %b%b%b want 111", ok1, ok2, ok3); end
    if (nw != 576) begin errors++; $display("FAIL rstmid_count: got %0d want 576", nw); end
    if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL rstmid_frame_done: got %0d want 1", fd_cnt - fd0); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_back_to_back();
    test_sof_resync();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
